// File: rtl/serial_rx32.sv
// 8N1 serial receiver that assembles four LSB-first bytes into one 32-bit word.
// The first byte received lands in data[7:0]; a partial word is dropped on a framing error or an inter-byte timeout.
module serial_rx32 #(
   parameter int CLK_PER_BIT = 50,
   parameter int GAP_TIMEOUT = 1000,
   parameter int CTR_SIZE    = $clog2(CLK_PER_BIT)
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rx,
   output logic [31:0] data,
   output logic        new_data,
   output logic        frame_err,
   output logic        timeout,
   output logic        busy
);

   localparam int GAP_W = $clog2(GAP_TIMEOUT + 1);
   localparam logic [CTR_SIZE-1:0] CTR_MAX  = CTR_SIZE'(CLK_PER_BIT - 1);
   localparam logic [CTR_SIZE-1:0] CTR_HALF = CTR_SIZE'(CLK_PER_BIT / 2 - 1);
   localparam logic [GAP_W-1:0]    GAP_LAST = GAP_W'(GAP_TIMEOUT - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, RECOVER} state_t;

   state_t              state, state_d;
   logic                rx_meta, rx_s;
   logic [CTR_SIZE-1:0] ctr, ctr_d;
   logic [2:0]          bit_ctr, bit_ctr_d;
   logic [7:0]          shift, shift_d;
   logic [1:0]          byte_cnt, byte_cnt_d;
   logic [23:0]         word, word_d;
   logic [GAP_W-1:0]    gap, gap_d;
   logic [31:0]         data_d;
   logic                new_data_d, frame_err_d, timeout_d;

   assign busy = (state != IDLE) || (byte_cnt != 2'd0);

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta   <= 1'b1;
         rx_s      <= 1'b1;
         state     <= IDLE;
         ctr       <= '0;
         bit_ctr   <= '0;
         shift     <= '0;
         byte_cnt  <= '0;
         word      <= '0;
         gap       <= '0;
         data      <= '0;
         new_data  <= 1'b0;
         frame_err <= 1'b0;
         timeout   <= 1'b0;
      end else begin
         rx_meta   <= rx;
         rx_s      <= rx_meta;
         state     <= state_d;
         ctr       <= ctr_d;
         bit_ctr   <= bit_ctr_d;
         shift     <= shift_d;
         byte_cnt  <= byte_cnt_d;
         word      <= word_d;
         gap       <= gap_d;
         data      <= data_d;
         new_data  <= new_data_d;
         frame_err <= frame_err_d;
         timeout   <= timeout_d;
      end
   end

   // The gap counter only runs while idling mid-word, so it defaults to clear everywhere else.
   always_comb begin
      state_d     = state;
      ctr_d       = ctr;
      bit_ctr_d   = bit_ctr;
      shift_d     = shift;
      byte_cnt_d  = byte_cnt;
      word_d      = word;
      gap_d       = '0;
      data_d      = data;
      new_data_d  = 1'b0;
      frame_err_d = 1'b0;
      timeout_d   = 1'b0;

      case (state)
         IDLE: begin
            if (!rx_s) begin
               state_d   = START;
               ctr_d     = '0;
               bit_ctr_d = '0;
            end else if (byte_cnt != 2'd0) begin
               if (gap == GAP_LAST) begin
                  timeout_d  = 1'b1;
                  byte_cnt_d = 2'd0;
               end else begin
                  gap_d = gap + 1'b1;
               end
            end
         end

         START: begin
            if (ctr == CTR_HALF) begin
               ctr_d = '0;
               if (rx_s) state_d = IDLE;
               else      state_d = DATA;
            end else begin
               ctr_d = ctr + 1'b1;
            end
         end

         DATA: begin
            if (ctr == CTR_MAX) begin
               ctr_d          = '0;
               shift_d[bit_ctr] = rx_s;
               if (bit_ctr == 3'd7) begin
                  bit_ctr_d = '0;
                  state_d   = STOP;
               end else begin
                  bit_ctr_d = bit_ctr + 1'b1;
               end
            end else begin
               ctr_d = ctr + 1'b1;
            end
         end

         // Leaving at mid stop bit leaves half a bit to spot a back-to-back start bit.
         STOP: begin
            if (ctr == CTR_MAX) begin
               ctr_d = '0;
               if (rx_s) begin
                  state_d = IDLE;
                  case (byte_cnt)
                     2'd0: word_d[7:0]   = shift;
                     2'd1: word_d[15:8]  = shift;
                     2'd2: word_d[23:16] = shift;
                     default: begin
                        data_d     = {shift, word};
                        new_data_d = 1'b1;
                     end
                  endcase
                  byte_cnt_d = (byte_cnt == 2'd3) ? 2'd0 : byte_cnt + 2'd1;
               end else begin
                  frame_err_d = 1'b1;
                  byte_cnt_d  = 2'd0;
                  state_d     = RECOVER;
               end
            end else begin
               ctr_d = ctr + 1'b1;
            end
         end

         RECOVER: begin
            if (rx_s) state_d = IDLE;
         end

         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_serial_rx32.sv
// Scoreboarded bench for serial_rx32: a bit-banged 8N1 sender feeds rx, and a monitor
// matches every output strobe against the queue of expected events.
module tb_serial_rx32;

   localparam int CPB = 50;
   localparam int GAP = 1000;

   logic        clk = 1'b0;
   logic        rst;
   logic        rx;
   logic [31:0] data;
   logic        new_data, frame_err, timeout, busy;

   typedef enum logic [1:0] {EV_WORD, EV_FERR, EV_TMO} ev_kind_t;
   typedef struct packed {
      ev_kind_t    kind;
      logic [31:0] value;
   } ev_t;

   ev_t exp_q[$];
   int  tests_run = 0;
   int  failures  = 0;

   serial_rx32 #(.CLK_PER_BIT(CPB), .GAP_TIMEOUT(GAP)) dut (
      .clk(clk), .rst(rst), .rx(rx), .data(data), .new_data(new_data),
      .frame_err(frame_err), .timeout(timeout), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      tests_run++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   // Each strobe consumes one expected event; data must match in every case, so aborts prove it held.
   always @(negedge clk) begin : monitor
      ev_kind_t kind;
      ev_t      ev;
      if (!rst && (new_data || frame_err || timeout)) begin
         kind = new_data ? EV_WORD : (frame_err ? EV_FERR : EV_TMO);
         if (exp_q.size() == 0) begin
            tests_run++;
            failures++;
            $display("[TB] FAIL unexpected strobe: got kind %0d data %h, expected no event", kind, data);
         end else begin
            ev = exp_q.pop_front();
            checkOutput("event kind", 32'(kind), 32'(ev.kind));
            checkOutput("event data", data, ev.value);
            checkOutput("strobe count", 32'(new_data) + 32'(frame_err) + 32'(timeout), 32'd1);
         end
      end
   end

   task automatic sendByte(input logic [7:0] b, input logic stop_val);
      rx = 1'b0;
      repeat (CPB) @(posedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (CPB) @(posedge clk);
      end
      rx = stop_val;
      repeat (CPB) @(posedge clk);
      rx = 1'b1;
   endtask

   task automatic applyStimulus(input logic [31:0] word);
      exp_q.push_back('{kind: EV_WORD, value: word});
      for (int i = 0; i < 4; i++) sendByte(word[8*i +: 8], 1'b1);
   endtask

   task automatic waitDrain(input string name);
      int n = 0;
      while (exp_q.size() != 0 && n < 500) begin
         @(posedge clk);
         n++;
      end
      checkOutput(name, 32'(exp_q.size()), 32'd0);
      exp_q.delete();
   endtask

   initial begin : watchdog
      #2ms;
      $display("[TB] FAIL watchdog: simulation still running, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rx  = 1'b1;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("reset data", data, 32'h0);
      checkOutput("reset flags", {28'h0, new_data, frame_err, timeout, busy}, 32'h0);
      @(posedge clk);
      rst = 1'b0;
      repeat (5) @(posedge clk);

      applyStimulus(32'hDEADBEEF);
      waitDrain("word DEADBEEF drain");

      applyStimulus(32'h01234567);
      applyStimulus(32'h89ABCDEF);
      waitDrain("back-to-back drain");

      exp_q.push_back('{kind: EV_FERR, value: 32'h89ABCDEF});
      sendByte(8'h11, 1'b1);
      sendByte(8'h22, 1'b0);
      repeat (3 * CPB) @(posedge clk);
      waitDrain("frame error drain");
      @(negedge clk);
      checkOutput("busy after frame error", 32'(busy), 32'd0);
      @(posedge clk);
      applyStimulus(32'hA5A5A5A5);
      waitDrain("word A5A5A5A5 drain");

      rx = 1'b0;
      repeat (10) @(posedge clk);
      rx = 1'b1;
      repeat (CPB) @(posedge clk);
      @(negedge clk);
      checkOutput("busy after glitch", 32'(busy), 32'd0);
      checkOutput("data after glitch", data, 32'hA5A5A5A5);
      @(posedge clk);

      exp_q.push_back('{kind: EV_TMO, value: 32'hA5A5A5A5});
      sendByte(8'h34, 1'b1);
      sendByte(8'h12, 1'b1);
      @(negedge clk);
      checkOutput("busy mid word", 32'(busy), 32'd1);
      repeat (GAP + 100) @(posedge clk);
      waitDrain("timeout drain");
      @(negedge clk);
      checkOutput("busy after timeout", 32'(busy), 32'd0);
      @(posedge clk);
      applyStimulus(32'h0000FFFF);
      waitDrain("word 0000FFFF drain");

      sendByte(8'h77, 1'b1);
      sendByte(8'h66, 1'b1);
      rx = 1'b0;
      repeat (CPB) @(posedge clk);
      rx = 1'b1;
      repeat (3 * CPB) @(posedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checkOutput("mid-word reset data", data, 32'h0);
      checkOutput("mid-word reset flags", {28'h0, new_data, frame_err, timeout, busy}, 32'h0);
      @(posedge clk);
      rst = 1'b0;
      repeat (5) @(posedge clk);
      applyStimulus(32'hCAFEF00D);
      waitDrain("word CAFEF00D drain");
      repeat (2 * CPB) @(posedge clk);

      $display("[TB] %0d tests run, %0d failed", tests_run, failures);
      $finish;
   end

endmodule
